// File: rtl/ahb_pkg.sv
// Shared AHB-Lite/AHB2 encodings used by the master ports and anything else on the bus.
// Contents:
//   htrans_e  - HTRANS transfer types (IDLE/BUSY/NONSEQ/SEQ)
//   hresp_e   - HRESP responses (OKAY/ERROR/RETRY/SPLIT)
//   HburstSingle, HsizeByte/Half/Word - burst and size encodings
//   is_retry() - true for the two-cycle responses that ask for a reissue
package ahb_pkg;

  typedef enum logic [1:0] {
    HtransIdle   = 2'b00,
    HtransBusy   = 2'b01,
    HtransNonseq = 2'b10,
    HtransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    HrespOkay  = 2'b00,
    HrespError = 2'b01,
    HrespRetry = 2'b10,
    HrespSplit = 2'b11
  } hresp_e;

  localparam logic [2:0] HburstSingle = 3'b000;

  localparam logic [2:0] HsizeByte = 3'b000;
  localparam logic [2:0] HsizeHalf = 3'b001;
  localparam logic [2:0] HsizeWord = 3'b010;

  // RETRY and SPLIT both mean "try the same transfer again later".
  function automatic logic is_retry(input logic [1:0] resp);
    return (resp == HrespRetry) || (resp == HrespSplit);
  endfunction

endpackage

// File: rtl/ahb_master_port.sv
// Master-side AHB bridge between one CPU memory port (IM or DM) and the shared AHB bus.
// A CPU single-word request becomes one arbitrated SINGLE transfer; completion is reported
// with a one-cycle ready pulse (err qualifies it) and registered read data.
//
// Ports:
//   HCLK, HRESETn          bus clock (rising edge), async active-low reset
//   enable/write/addr/     CPU request, held until ready; captured when leaving idle
//   wdata/size
//   rdata, ready, err      registered read data, completion pulse, error-completion flag
//   HBUSREQ, HGRANT        arbiter handshake
//   HADDR/HTRANS/HWRITE/   AHB master outputs, all driven from flops
//   HSIZE/HBURST/HWDATA
//   HRDATA/HREADY/HRESP    AHB slave response
//
// Build option: define AHB_MASTER_RETRY_LIMIT_EN to bound RETRY/SPLIT reissues to RETRY_MAX;
// after that many reissues the next RETRY/SPLIT completes the request with err=1.
// Without it, retries are unlimited.
module ahb_master_port
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RETRY_MAX = 8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  // CPU side
  input  logic              enable,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        size,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  // AHB side
  output logic              HBUSREQ,
  input  logic              HGRANT,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic [1:0]        HRESP
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StAddr,
    StData,
    StRetry,
    StDone
  } state_e;

  state_e            state_q;

  // Captured request; the bus side never looks at the live CPU inputs.
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        size_q;

  logic [1:0]        trans_q;
  logic              busreq_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ready_q;
  logic              err_q;

`ifdef AHB_MASTER_RETRY_LIMIT_EN
  localparam int unsigned CntW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [CntW-1:0] RetryMaxC = CntW'(RETRY_MAX);

  logic [CntW-1:0] retry_cnt_q;
  // Set when a RETRY/SPLIT arrives with the budget already spent; the RETRY state then
  // finishes the request with an error instead of re-requesting the bus.
  logic            retry_abort_q;
`else
  logic unused_retry_max;
  assign unused_retry_max = ^RETRY_MAX;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      size_q        <= '0;
      trans_q       <= HtransIdle;
      busreq_q      <= 1'b0;
      rdata_q       <= '0;
      ready_q       <= 1'b0;
      err_q         <= 1'b0;
`ifdef AHB_MASTER_RETRY_LIMIT_EN
      retry_cnt_q   <= '0;
      retry_abort_q <= 1'b0;
`endif
    end else begin
      // Completion flags are pulses; only the transitions into StDone raise them.
      ready_q <= 1'b0;
      err_q   <= 1'b0;

      case (state_q)
        StIdle: begin
`ifdef AHB_MASTER_RETRY_LIMIT_EN
          retry_cnt_q   <= '0;
          retry_abort_q <= 1'b0;
`endif
          if (enable) begin
            addr_q   <= addr;
            write_q  <= write;
            wdata_q  <= wdata;
            size_q   <= size;
            busreq_q <= 1'b1;
            if (HGRANT && HREADY) begin
              // Bus already parked on us: go straight to the address phase.
              state_q <= StAddr;
              trans_q <= HtransNonseq;
            end else begin
              state_q <= StReq;
            end
          end
        end

        StReq: begin
          if (HGRANT && HREADY) begin
            state_q <= StAddr;
            trans_q <= HtransNonseq;
          end
        end

        StAddr: begin
          if (HREADY) begin
            state_q  <= StData;
            trans_q  <= HtransIdle;
            busreq_q <= 1'b0;
          end
        end

        StData: begin
          if (is_retry(HRESP)) begin
            // First cycle of the two-cycle response (a response that skips the first
            // cycle is treated the same way); RETRY waits for the second cycle.
            state_q <= StRetry;
`ifdef AHB_MASTER_RETRY_LIMIT_EN
            if (retry_cnt_q == RetryMaxC) begin
              retry_abort_q <= 1'b1;
            end else begin
              retry_cnt_q <= retry_cnt_q + CntW'(1);
            end
`endif
          end else if (HREADY) begin
            // OKAY completes normally; ERROR is acted on in its second (HREADY=1) cycle.
            state_q <= StDone;
            ready_q <= 1'b1;
            if (HRESP == HrespError) begin
              err_q <= 1'b1;
            end else if (!write_q) begin
              rdata_q <= HRDATA;
            end
          end
        end

        StRetry: begin
          if (HREADY) begin
`ifdef AHB_MASTER_RETRY_LIMIT_EN
            if (retry_abort_q) begin
              state_q <= StDone;
              ready_q <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q  <= StReq;
              busreq_q <= 1'b1;
            end
`else
            state_q  <= StReq;
            busreq_q <= 1'b1;
`endif
          end
        end

        StDone: begin
          // enable is still high here (held until ready); a new request is only taken
          // from StIdle, one cycle later.
          state_q <= StIdle;
        end

        default: begin
          state_q  <= StIdle;
          trans_q  <= HtransIdle;
          busreq_q <= 1'b0;
        end
      endcase
    end
  end

  assign HADDR   = addr_q;
  assign HWRITE  = write_q;
  assign HSIZE   = size_q;
  assign HWDATA  = wdata_q;
  assign HTRANS  = trans_q;
  assign HBUSREQ = busreq_q;
  assign HBURST  = HburstSingle;

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;

endmodule

// File: tb/tb_ahb_master_port.sv
// Bench for ahb_master_port. The bench plays CPU, arbiter and slave. Each request is
// described by a plan (grant delay, address/data wait states, retries, final response);
// from that plan the bench lays out the bus phase that must be visible after every clock
// edge and queues the resulting output values. One compare process checks every cycle.
module tb_ahb_master_port;
  import ahb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned RM = 2;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          enable = 1'b0;
  logic          write = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [2:0]    size = '0;
  logic [DW-1:0] rdata;
  logic          ready;
  logic          err;
  logic          HBUSREQ;
  logic          HGRANT = 1'b0;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [2:0]    HBURST;
  logic [DW-1:0] HWDATA;
  logic [DW-1:0] HRDATA = '0;
  logic          HREADY = 1'b1;
  logic [1:0]    HRESP = 2'b00;

  ahb_master_port #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .RETRY_MAX(RM)
  ) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .enable (enable),
    .write  (write),
    .addr   (addr),
    .wdata  (wdata),
    .size   (size),
    .rdata  (rdata),
    .ready  (ready),
    .err    (err),
    .HBUSREQ(HBUSREQ),
    .HGRANT (HGRANT),
    .HADDR  (HADDR),
    .HTRANS (HTRANS),
    .HWRITE (HWRITE),
    .HSIZE  (HSIZE),
    .HBURST (HBURST),
    .HWDATA (HWDATA),
    .HRDATA (HRDATA),
    .HREADY (HREADY),
    .HRESP  (HRESP)
  );

  always #5 HCLK = ~HCLK;

  // Bus phase the port must be in after an edge, as seen from the outside.
  typedef enum logic [2:0] {PIdle, PReq, PAddr, PData, PRetry, PDone} phase_e;

  typedef struct {
    phase_e      ph;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic [31:0] rdat;
    logic        err;
  } exp_t;

  exp_t expq[$];
  exp_t ce;

  int vectors = 0;
  int miscompares = 0;

  // Plan of the request in flight and the read-data model.
  logic [31:0] cur_addr, cur_wd, model_rdata = '0;
  logic [2:0]  cur_sz;
  logic        cur_wr;
  bit          cur_first = 0;

  int edge_no = 0;
  int start_edge = 0;
  int last_ready_edge = -100;
  int nonseq_cnt = 0;
  int ready_cnt = 0;
  int err_cnt = 0;
  logic [1:0] prev_trans = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic rnd1();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [1:0] rnd2();
    return 2'($urandom);
  endfunction

  // Compare process: one expectation per clock edge, checked on the falling edge.
  initial begin
    forever begin
      @(negedge HCLK);
      if (HTRANS == HtransNonseq && prev_trans != HtransNonseq) nonseq_cnt++;
      prev_trans = HTRANS;
      if (ready) begin
        last_ready_edge = edge_no;
        ready_cnt++;
        if (err) err_cnt++;
      end
      if (expq.size() > 0) begin
        ce = expq.pop_front();
        chk("htrans", 32'(HTRANS), (ce.ph == PAddr) ? 32'(HtransNonseq) : 32'(HtransIdle));
        chk("hbusreq", 32'(HBUSREQ), 32'((ce.ph == PReq) || (ce.ph == PAddr)));
        chk("ready", 32'(ready), 32'(ce.ph == PDone));
        chk("err", 32'(err), 32'((ce.ph == PDone) && ce.err));
        chk("rdata", rdata, ce.rdat);
        chk("hburst", 32'(HBURST), 32'(HburstSingle));
        if (ce.ph == PAddr) begin
          chk("haddr", HADDR, ce.addr);
          chk("hwrite", 32'(HWRITE), 32'(ce.wr));
          chk("hsize", 32'(HSIZE), 32'(ce.sz));
        end
        if (ce.ph == PData) chk("hwdata", HWDATA, ce.wd);
      end
    end
  end

  // Drive one clock edge's inputs and queue the outputs expected after it.
  // Called just after a falling edge; returns just after the next falling edge.
  task automatic edge_(input bit in_txn, input logic g, input logic rdy, input logic [1:0] resp,
                       input logic [31:0] hrd, input phase_e ph, input logic errf);
    exp_t e;
    if (cur_first) begin
      enable = 1'b1;
      write  = cur_wr;
      addr   = cur_addr;
      wdata  = cur_wd;
      size   = cur_sz;
      cur_first = 0;
    end else begin
      // Outside the capture edge the CPU inputs are noise the port must ignore.
      enable = in_txn ? rnd1() : 1'b0;
      write  = rnd1();
      addr   = $urandom;
      wdata  = $urandom;
      size   = 3'($urandom);
    end
    HGRANT = g;
    HREADY = rdy;
    HRESP  = resp;
    HRDATA = hrd;
    e.ph = ph;
    e.addr = cur_addr;
    e.wr = cur_wr;
    e.sz = cur_sz;
    e.wd = cur_wd;
    e.rdat = model_rdata;
    e.err = errf;
    expq.push_back(e);
    edge_no++;
    @(negedge HCLK);
    #1;
  endtask

  task automatic run_txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] sz, input logic [31:0] rd, input int g0,
                         input int aw, input int dw, input int nretry, input bit err_final);
    int g;
    bit done;
    logic [1:0] rresp;
    cur_wr = wr;
    cur_addr = a;
    cur_wd = wd;
    cur_sz = sz;
    cur_first = 1;
    start_edge = edge_no + 1;
    done = 0;
    for (int i = 0; i <= nretry && !done; i++) begin
      g = (i == 0) ? g0 : $urandom_range(0, 2);
      for (int j = 0; j < g; j++) edge_(1, 1'b0, rnd1(), rnd2(), $urandom, PReq, 1'b0);
      edge_(1, 1'b1, 1'b1, rnd2(), $urandom, PAddr, 1'b0);
      for (int j = 0; j < aw; j++) edge_(1, rnd1(), 1'b0, rnd2(), $urandom, PAddr, 1'b0);
      edge_(1, rnd1(), 1'b1, rnd2(), $urandom, PData, 1'b0);
      for (int j = 0; j < dw; j++) edge_(1, rnd1(), 1'b0, HrespOkay, $urandom, PData, 1'b0);
      if (i < nretry) begin
        rresp = rnd1() ? HrespRetry : HrespSplit;
        edge_(1, rnd1(), 1'b0, rresp, $urandom, PRetry, 1'b0);
        if (rnd1()) edge_(1, rnd1(), 1'b0, rnd2(), $urandom, PRetry, 1'b0);
`ifdef AHB_MASTER_RETRY_LIMIT_EN
        if (i == RM) begin
          edge_(1, rnd1(), 1'b1, rresp, $urandom, PDone, 1'b1);
          done = 1;
        end else begin
          edge_(1, rnd1(), 1'b1, rresp, $urandom, PReq, 1'b0);
        end
`else
        edge_(1, rnd1(), 1'b1, rresp, $urandom, PReq, 1'b0);
`endif
      end else if (err_final) begin
        edge_(1, rnd1(), 1'b0, HrespError, $urandom, PData, 1'b0);
        edge_(1, rnd1(), 1'b1, HrespError, $urandom, PDone, 1'b1);
      end else begin
        if (!wr) model_rdata = rd;
        edge_(1, rnd1(), 1'b1, HrespOkay, rd, PDone, 1'b0);
      end
    end
    // Back to idle; enable may still be high here and must not start anything.
    edge_(1, rnd1(), rnd1(), rnd2(), $urandom, PIdle, 1'b0);
  endtask

  task automatic gap(input int n);
    for (int j = 0; j < n; j++) edge_(0, rnd1(), rnd1(), rnd2(), $urandom, PIdle, 1'b0);
  endtask

  initial begin
    int r0, e0, lat;
    // Reset with busy-looking inputs: outputs must still sit at their reset values.
    enable = 1'b1;
    write = 1'b1;
    addr = 32'hFFFF_FFFF;
    wdata = 32'hFFFF_FFFF;
    size = 3'b111;
    HGRANT = 1'b1;
    @(negedge HCLK);
    #1;
    chk("rst_htrans", 32'(HTRANS), 32'd0);
    chk("rst_hbusreq", 32'(HBUSREQ), 32'd0);
    chk("rst_haddr", HADDR, 32'd0);
    chk("rst_hwrite", 32'(HWRITE), 32'd0);
    chk("rst_hsize", 32'(HSIZE), 32'd0);
    chk("rst_hwdata", HWDATA, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    HRESETn = 1'b1;
    gap(2);

    // Parked read: NONSEQ after the first edge, ready with data after the third.
    nonseq_cnt = 0;
    run_txn(1'b0, 32'h0000_0100, 32'h0, HsizeWord, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    lat = last_ready_edge - start_edge + 1;
    chk("parked_latency", 32'(lat), 32'd3);
    chk("parked_rdata", rdata, 32'hDEAD_BEEF);
    chk("parked_nonseq_issues", 32'(nonseq_cnt), 32'd1);

    // Arbitrated write: grant withheld for 4 edges.
    r0 = ready_cnt;
    run_txn(1'b1, 32'h0000_0040, 32'h1234_5678, HsizeWord, 32'h0, 4, 0, 0, 0, 0);
    lat = last_ready_edge - start_edge + 1;
    chk("arb_latency", 32'(lat), 32'd7);
    chk("arb_ready_pulses", 32'(ready_cnt - r0), 32'd1);
    chk("arb_rdata_kept", rdata, 32'hDEAD_BEEF);

    // Three data-phase wait states on a parked read.
    run_txn(1'b0, 32'h0000_0200, 32'h0, HsizeHalf, 32'hCAFE_0123, 0, 0, 3, 0, 0);
    lat = last_ready_edge - start_edge + 1;
    chk("wait_latency", 32'(lat), 32'd6);
    gap(1);

    // One RETRY, then OKAY: the address is issued twice, one completion.
    nonseq_cnt = 0;
    r0 = ready_cnt;
    e0 = err_cnt;
    run_txn(1'b0, 32'h0000_0300, 32'h0, HsizeWord, 32'hA5A5_0001, 1, 0, 0, 1, 0);
    chk("retry_nonseq_issues", 32'(nonseq_cnt), 32'd2);
    chk("retry_ready_pulses", 32'(ready_cnt - r0), 32'd1);
    chk("retry_err_pulses", 32'(err_cnt - e0), 32'd0);
    chk("retry_rdata", rdata, 32'hA5A5_0001);

    // ERROR response on a read: err with ready, rdata untouched.
    e0 = err_cnt;
    run_txn(1'b0, 32'h0000_0400, 32'h0, HsizeByte, 32'h5555_AAAA, 0, 1, 1, 0, 1);
    chk("error_err_pulses", 32'(err_cnt - e0), 32'd1);
    chk("error_rdata_kept", rdata, 32'hA5A5_0001);
    gap(1);

`ifdef AHB_MASTER_RETRY_LIMIT_EN
    // Slave keeps answering RETRY: RM reissues, then an error completion.
    nonseq_cnt = 0;
    e0 = err_cnt;
    run_txn(1'b0, 32'h0000_0500, 32'h0, HsizeWord, 32'h0, 0, 0, 0, 3, 0);
    chk("limit_nonseq_issues", 32'(nonseq_cnt), 32'd3);
    chk("limit_err_pulses", 32'(err_cnt - e0), 32'd1);
    gap(1);
`endif

    // Reset asserted in the address phase: bus released at once, no completion.
    cur_wr = 1'b1;
    cur_addr = 32'h0000_0600;
    cur_wd = 32'h0BAD_F00D;
    cur_sz = HsizeWord;
    cur_first = 1;
    edge_(1, 1'b1, 1'b1, HrespOkay, 32'h0, PAddr, 1'b0);
    HRESETn = 1'b0;
    #1;
    chk("rstmid_htrans", 32'(HTRANS), 32'd0);
    chk("rstmid_hbusreq", 32'(HBUSREQ), 32'd0);
    chk("rstmid_ready", 32'(ready), 32'd0);
    chk("rstmid_haddr", HADDR, 32'd0);
    model_rdata = '0;
    edge_(0, 1'b1, 1'b1, HrespOkay, 32'h0, PIdle, 1'b0);
    HRESETn = 1'b1;
    gap(1);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      run_txn(rnd1(), $urandom, $urandom, 3'($urandom_range(0, 2)), $urandom,
              ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 4),
              $urandom_range(0, 2), $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
              ($urandom_range(0, 6) == 0));
      gap($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
